// File: rtl/prbs_bus_checker.sv
// prbs_bus_checker
// Receive-side LFSR word-sequence checker. It sits at the output of a
// WIDTH-bit pipe of unknown delay and locks onto the incoming stream by
// seeding a local LFSR from a received word. It then confirms the seed over
// LOCK_CNT matches and flywheels through errors while locked. It reports lock
// status, a per-word error pulse and saturating error and word counters.
//
// Valid/ready: there is no back-pressure. A word is consumed on every rising
// clock edge where in_vld is 1, and the checker is always ready. Cycles with
// in_vld = 0 leave the state untouched. On those cycles only the counter clear
// takes effect, and err reads 0.
//
// dbg_state encoding: 0 = SEED, 1 = HUNT, 2 = LOCKED.

module prbs_bus_checker #(
    parameter int              WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter int              LOCK_CNT   = 16,
    parameter int              UNLOCK_ERR = 4,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active low
    input  logic [WIDTH-1:0] in,
    input  logic             in_vld,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [1:0]       dbg_state
);

    // ------------------------------------------------------------------
    // State encoding and counter sizing
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_SEED   = 2'd0;
    localparam logic [1:0] ST_HUNT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // The hunt counter only has to count up to LOCK_CNT-1. The match that
    // would bring it to LOCK_CNT is the match that declares lock.
    localparam int HW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(UNLOCK_ERR + 1);

    localparam logic [HW-1:0] LOCK_LAST = HW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_ERR - 1);

    // Successor of a word in the generator's sequence
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] cur);
        return {cur[WIDTH-2:0], ^(cur & TAPS)};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [WIDTH-1:0] pred;
    logic [HW-1:0]    hunt_cnt;
    logic [MW-1:0]    miss_cnt;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] pred_nxt;
    logic [HW-1:0]    hunt_nxt;
    logic [MW-1:0]    miss_nxt;
    logic             word_hit;     // received word equals the prediction
    logic             seedable;     // all-zero is the LFSR lock-up value
    logic             lock_word;    // valid word checked while locked
    logic             lock_miss;    // valid word mismatched while locked

    assign word_hit = (in == pred);
    assign seedable = |in;

    // Decide the next state, prediction and run counters from the current word
    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        hunt_nxt  = hunt_cnt;
        miss_nxt  = miss_cnt;
        lock_word = 1'b0;
        lock_miss = 1'b0;

        if (in_vld) begin
            case (state)
                ST_SEED: begin
                    // Take the received word as the generator's current state
                    if (seedable) begin
                        pred_nxt  = lfsr_next(in);
                        hunt_nxt  = '0;
                        state_nxt = ST_HUNT;
                    end
                end

                ST_HUNT: begin
                    if (word_hit) begin
                        pred_nxt = lfsr_next(pred);
                        if (hunt_cnt == LOCK_LAST) begin
                            state_nxt = ST_LOCKED;
                            hunt_nxt  = '0;
                            miss_nxt  = '0;
                        end else begin
                            hunt_nxt = hunt_cnt + 1'b1;
                        end
                    end else if (!seedable) begin
                        // Cannot reseed from zero, so fall back and wait
                        state_nxt = ST_SEED;
                        hunt_nxt  = '0;
                    end else begin
                        // The seed was wrong: restart the hunt from this word
                        pred_nxt = lfsr_next(in);
                        hunt_nxt = '0;
                    end
                end

                ST_LOCKED: begin
                    // The local sequence keeps running, so one corrupted
                    // word does not disturb the following predictions.
                    pred_nxt  = lfsr_next(pred);
                    lock_word = 1'b1;
                    if (word_hit) begin
                        miss_nxt = '0;
                    end else begin
                        lock_miss = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_nxt = ST_SEED;
                            miss_nxt  = '0;
                        end else begin
                            miss_nxt = miss_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state_nxt = ST_SEED;
                    hunt_nxt  = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    // FSM, prediction and run-length registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_SEED;
            pred     <= '0;
            hunt_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pred     <= pred_nxt;
            hunt_cnt <= hunt_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    // Registered status outputs: lock flag and single-cycle error pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            locked <= (state_nxt == ST_LOCKED);
            err    <= lock_miss;
        end
    end

    // Saturating counters; a clear wins over an increment on the same edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt  <= '0;
            word_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt  <= '0;
            word_cnt <= '0;
        end else begin
            if (lock_word && !(&word_cnt)) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (lock_miss && !(&err_cnt)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/prbs_bus_checker.md
Name: prbs_bus_checker

Overview:
- Receive-side counterpart to the word-sequence generator that drives the srl_bus delay line.
- Sits at the output of srl_bus (or any WIDTH-bit pipe) and checks each word against a locally regenerated LFSR word sequence.
- Self-synchronises to the incoming stream with no knowledge of the pipe delay, then reports lock status, per-word error pulses and saturating error/word counters.
- Used for on-board bring-up and in benches in place of a reference array.

Parameters:
- WIDTH, 8, data word width (>= 3).
- TAPS, 8'hB8, feedback mask of WIDTH bits. Next word = {cur[WIDTH-2:0], ^(cur & TAPS)}.
- LOCK_CNT, 16, consecutive matches in HUNT required to declare lock (>= 1).
- UNLOCK_ERR, 4, consecutive mismatches in LOCKED that drop lock (>= 1).
- CNT_W, 16, width of err_cnt and word_cnt.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst, input, 1, asynchronous, active-low reset.
- in, input, WIDTH, received data word.
- in_vld, input, 1, in is valid this cycle; only valid words are checked.
- clr_cnt, input, 1, synchronous clear of err_cnt and word_cnt.
- locked, output, 1, checker is in LOCKED.
- err, output, 1, one-cycle pulse: the previous valid word mismatched while LOCKED.
- err_cnt, output, CNT_W, saturating count of mismatches while LOCKED.
- word_cnt, output, CNT_W, saturating count of valid words checked while LOCKED.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - state=SEED, pred=0, hunt_cnt=0, miss_cnt=0.
  - locked=0, err=0, err_cnt=0, word_cnt=0.
- **General:** all outputs are registered. A decision on the word sampled at edge N is visible after edge N. Cycles with in_vld=0 change nothing except clr_cnt handling; err is 0 on those cycles.
- **SEED:**
  - On in_vld with in != 0: pred <= f(in), hunt_cnt <= 0, go to HUNT.
  - in == 0 is unseedable (lock-up value): stay in SEED.
- **HUNT:**
  - On in_vld with in == pred: pred <= f(pred), hunt_cnt++.
  - When the match makes hunt_cnt reach LOCK_CNT: go to LOCKED, locked=1 from the next cycle, miss_cnt=0.
  - On in_vld with a mismatch: reseed, pred <= f(in), hunt_cnt <= 0, stay in HUNT. If in == 0, go to SEED instead.
  - No err pulses and no counting in HUNT.
- **LOCKED (flywheel):**
  - Every valid word: pred <= f(pred), regardless of match. word_cnt++ (saturating).
  - Match: miss_cnt <= 0.
  - Mismatch: err=1 for one cycle, err_cnt++ (saturating at 2^CNT_W-1), miss_cnt++.
  - When miss_cnt reaches UNLOCK_ERR: go to SEED, locked <= 0 on the same edge. The err pulse for that word is still issued.
- **Counters:**
  - Saturate at all-ones; no wrap.
  - clr_cnt=1 zeroes both counters on that edge and takes priority over an increment in the same cycle.
  - clr_cnt affects neither state nor locked.
- **Reset mid-operation:** immediate return to reset values. There is no memory of the previous stream.

Test Plan:
- **Clean lock:** WIDTH=8, TAPS=B8, LOCK_CNT=16. Drive the sequence 0x01,0x02,0x04,0x08,0x11,… continuously valid → locked rises after edge 17 (1 seed + 16 matches); err stays 0; word_cnt counts 1 per word after lock.
- **Single error while locked:** corrupt one word (XOR 0x10) → err pulses exactly once, err_cnt=1, locked stays 1, and the next uncorrupted word matches (flywheel holds).
- **Loss of lock:** force 4 consecutive corrupted words with UNLOCK_ERR=4 → 4 err pulses, err_cnt=4, locked falls on the 4th, state SEED. Resuming a clean stream relocks after 17 valid words.
- **Gaps and zero seed:** insert random in_vld=0 bubbles and start the stream with 0x00 → 0x00 is ignored in SEED; bubbles never cause err or change counts; lock is reached after 17 valid words.
- **Saturation and clear:** CNT_W=4, 20 corrupted words spread to stay locked → err_cnt holds 15. Assert clr_cnt together with a mismatch → err_cnt=0 after that edge and err still pulses.
- **Async reset mid-lock:** pull rst low between clock edges while locked → all outputs zero immediately, without waiting for a clock edge.
